// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the PC / branch datapath:
//   - funct3 condition codes of the conditional-branch instructions
//   - pcState_e : two-state control of the PC unit (RUN, TRAP)
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pcState_e;

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Decodes funct3 into the comparator signedness select and the branch outcome.
// Ports:
//   funct3   in  3  branch condition code
//   BrEq     in  1  rs1 == rs2 from the comparator
//   BrLT     in  1  rs1 <  rs2 from the comparator (signedness chosen by BrUn)
//   BrUn     out 1  comparator unsigned select (BLTU/BGEU)
//   condTrue out 1  branch condition holds
// -----------------------------------------------------------------------------
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       BrUn,
  output logic       condTrue
);

  assign BrUn = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);

  always_comb begin
    // NOTE: default assigned before the case so every path drives condTrue;
    // otherwise the unlisted codes (010/011) would infer a latch.
    condTrue = 1'b0;
    case (funct3)
      F3_BEQ:           condTrue = BrEq;
      F3_BNE:           condTrue = !BrEq;
      F3_BLT,  F3_BLTU: condTrue = BrLT;
      F3_BGE,  F3_BGEU: condTrue = !BrLT;
      default:          condTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
// Program counter with single-cycle branch/jump redirect and a trap on
// targets that are not 4-byte aligned (target[1] set). The trap holds the PC
// until trap_ack, which vectors to TRAP_VEC.
// Optional feature macro: BRANCH_PERF_EN adds branch/taken-branch counters.
// Parameters: WIDTH, RESET_PC, TRAP_VEC.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             hold PC this cycle (ignored in TRAP)
//   branch/jump/jalr  control-flow class of current instruction
//   funct3            branch condition code
//   BrEq, BrLT        comparator results;  BrUn  comparator unsigned select
//   imm, rs1          immediate and jalr base
//   pc, pc_plus4      current PC and PC+4
//   taken             control transfer selected this cycle
//   trap_valid/trap_pc/trap_ack  misaligned-target trap handshake
//   br_count, br_taken_count     (BRANCH_PERF_EN only) 32-bit counters
// -----------------------------------------------------------------------------
module pc_branch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs1,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             taken,
  output logic             trap_valid,
  output logic [WIDTH-1:0] trap_pc,
  input  logic             trap_ack
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]      br_count,
  output logic [31:0]      br_taken_count
`endif
);

  pcState_e         state;
  logic             condTrue;
  logic [WIDTH-1:0] jalrSum;
  logic [WIDTH-1:0] target;

  branch_cond uCond (
    .funct3   (funct3),
    .BrEq     (BrEq),
    .BrLT     (BrLT),
    .BrUn     (BrUn),
    .condTrue (condTrue)
  );

  assign pc_plus4 = pc + WIDTH'(4);
  assign jalrSum  = rs1 + imm;
  // jalr clears bit 0 of its sum; jalr wins over jump/branch.
  assign target   = jalr ? {jalrSum[WIDTH-1:1], 1'b0} : (pc + imm);
  assign taken    = (state == RUN) && (jalr || jump || (branch && condTrue));
  assign trap_valid = (state == TRAP);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      pc      <= RESET_PC;
      state   <= RUN;
      trap_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (!taken) begin
              pc <= pc_plus4;
            end else if (target[1]) begin
              // Misaligned target: PC stays on the offending instruction.
              trap_pc <= target;
              state   <= TRAP;
            end else begin
              pc <= target;
            end
          end
        end
        TRAP: begin
          if (trap_ack) begin
            pc    <= TRAP_VEC;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if ((state == RUN) && branch && !stall) begin
      br_count <= br_count + 32'd1;
      if (condTrue) begin
        br_taken_count <= br_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_unit
// Directed stimulus against a behavioural PC model; outputs are compared with
// the model on every falling edge, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        BrEq = 1'b0;
  logic        BrLT = 1'b0;
  logic        BrUn;
  logic [31:0] imm = 32'h0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        trap_ack = 1'b0;
`ifdef BRANCH_PERF_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .funct3     (funct3),
    .BrEq       (BrEq),
    .BrLT       (BrLT),
    .BrUn       (BrUn),
    .imm        (imm),
    .rs1        (rs1),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .taken      (taken),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_ack   (trap_ack)
`ifdef BRANCH_PERF_EN
    ,
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mPc = 32'h0;
  bit          mTrap = 1'b0;
  logic [31:0] mTrapPc = 32'h0;
  logic [31:0] mBr = 32'h0;
  logic [31:0] mBrTaken = 32'h0;
  bit          mValid = 1'b0;

  // Branch outcome straight from the condition-code table.
  function automatic bit condOf(input logic [2:0] f, input bit eq, input bit lt);
    case (f)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelTarget();
    if (jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
    return mPc + imm;
  endfunction

  function automatic bit modelTaken();
    return !mTrap && (jalr || jump || (branch && condOf(funct3, BrEq, BrLT)));
  endfunction

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = modelTarget();
    if (rst) begin
      mPc = 32'h0; mTrap = 1'b0; mTrapPc = 32'h0;
      mBr = 32'h0; mBrTaken = 32'h0; mValid = 1'b1;
    end else if (mValid) begin
      if (mTrap) begin
        if (trap_ack) begin
          mPc = 32'h100; mTrap = 1'b0;
        end
      end else if (!stall) begin
        if (branch) begin
          mBr = mBr + 1;
          if (condOf(funct3, BrEq, BrLT)) mBrTaken = mBrTaken + 1;
        end
        if (!modelTaken())         mPc = mPc + 4;
        else if (tgt % 4 == 2 || tgt % 4 == 3) begin
          mTrap = 1'b1; mTrapPc = tgt;
        end else                   mPc = tgt;
      end
    end
  end

  // Compare process: every falling edge once the model is initialised.
  always @(negedge clk) begin
    if (mValid) begin
      check("cmp_pc", pc, mPc);
      check("cmp_pc_plus4", pc_plus4, mPc + 4);
      check("cmp_taken", {31'h0, taken}, {31'h0, modelTaken()});
      check("cmp_BrUn", {31'h0, BrUn}, {31'h0, (funct3 == 3'b110 || funct3 == 3'b111)});
      check("cmp_trap_valid", {31'h0, trap_valid}, {31'h0, mTrap});
      check("cmp_trap_pc", trap_pc, mTrapPc);
`ifdef BRANCH_PERF_EN
      check("cmp_br_count", br_count, mBr);
      check("cmp_br_taken_count", br_taken_count, mBrTaken);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    funct3 = 3'b000; BrEq = 1'b0; BrLT = 1'b0; imm = 32'h0; rs1 = 32'h0;
    trap_ack = 1'b0;
  endtask

  task automatic doJump(input logic [31:0] off);
    idle(); jump = 1'b1; imm = off;
    tick();
    idle();
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
    check("reset_pc", pc, 32'h0);
    check("reset_pc_plus4", pc_plus4, 32'h4);
    check("reset_trap_valid", {31'h0, trap_valid}, 32'h0);
    tick(); tick(); tick();
    check("seq_pc_12", pc, 32'd12);

    // Taken BLT at 0x40.
    doJump(32'h34);
    check("jump_to_40", pc, 32'h40);
    branch = 1'b1; funct3 = 3'b100; BrLT = 1'b1; imm = 32'h20;
    #1 check("blt_taken", {31'h0, taken}, 32'h1);
    tick(); idle();
    check("blt_pc_60", pc, 32'h60);

    // Not-taken BLT at 0x40.
    doJump(32'hFFFF_FFE0);
    branch = 1'b1; funct3 = 3'b100; BrLT = 1'b0; imm = 32'h20;
    #1 check("blt_not_taken", {31'h0, taken}, 32'h0);
    tick(); idle();
    check("blt_pc_44", pc, 32'h44);

    // BGEU at 0x100 with negative offset.
    doJump(32'hBC);
    check("jump_to_100", pc, 32'h100);
    branch = 1'b1; funct3 = 3'b111; BrLT = 1'b0; imm = 32'hFFFF_FFF8;
    #1 check("bgeu_BrUn", {31'h0, BrUn}, 32'h1);
    tick(); idle();
    check("bgeu_pc_f8", pc, 32'hF8);

    // jalr beats a true branch; bit 0 of the sum is cleared.
    jalr = 1'b1; branch = 1'b1; funct3 = 3'b000; BrEq = 1'b1; rs1 = 32'h201; imm = 32'h0;
    tick(); idle();
    check("jalr_pc_200", pc, 32'h200);
    check("jalr_no_trap", {31'h0, trap_valid}, 32'h0);

    // Stall in RUN holds PC while taken stays visible.
    jump = 1'b1; imm = 32'h10; stall = 1'b1;
    #1 check("stall_taken_visible", {31'h0, taken}, 32'h1);
    tick(); idle();
    check("stall_pc_hold", pc, 32'h200);

    // trap_ack is ignored in RUN.
    trap_ack = 1'b1;
    tick(); idle();
    check("ack_in_run_ignored", pc, 32'h204);

    // Misaligned jump from 0x10 traps.
    doJump(32'hFFFF_FE0C);
    check("jump_to_10", pc, 32'h10);
    doJump(32'h6);
    check("trap_valid_set", {31'h0, trap_valid}, 32'h1);
    check("trap_pc_16", trap_pc, 32'h16);
    check("trap_pc_hold", pc, 32'h10);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; jump = 1'b1; imm = 32'h6;
      #1 check("trap_taken_low", {31'h0, taken}, 32'h0);
      tick();
      check("trap_valid_held", {31'h0, trap_valid}, 32'h1);
      check("trap_pc_held", trap_pc, 32'h16);
    end
    idle(); trap_ack = 1'b1;
    tick(); idle();
    check("trap_vec_pc", pc, 32'h100);
    check("trap_cleared", {31'h0, trap_valid}, 32'h0);

    // Reset in the middle of a trap.
    doJump(32'h6);
    check("trap2_valid", {31'h0, trap_valid}, 32'h1);
    rst = 1'b1; stall = 1'b1; trap_ack = 1'b0;
    tick();
    rst = 1'b0; idle();
    check("midtrap_reset_pc", pc, 32'h0);
    check("midtrap_reset_valid", {31'h0, trap_valid}, 32'h0);
    check("midtrap_reset_trap_pc", trap_pc, 32'h0);

    // pc_plus4 wrap at the top of the address space.
    doJump(32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    tick();
    check("wrap_pc", pc, 32'h0);

    // Reserved codes 010/011 never branch.
    branch = 1'b1; funct3 = 3'b010; BrEq = 1'b1; BrLT = 1'b1; imm = 32'h40;
    #1 check("f3_010_not_taken", {31'h0, taken}, 32'h0);
    tick(); idle();
    check("f3_010_pc", pc, 32'h4);

`ifdef BRANCH_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    branch = 1'b1; funct3 = 3'b000; BrEq = 1'b1; imm = 32'h8; tick();  // taken
    branch = 1'b1; funct3 = 3'b001; BrEq = 1'b0; imm = 32'h8; tick();  // taken
    branch = 1'b1; funct3 = 3'b100; BrLT = 1'b1; stall = 1'b1; tick(); // stalled
    stall = 1'b0; tick();                                               // taken
    idle(); branch = 1'b1; funct3 = 3'b101; BrLT = 1'b1; tick();        // not taken
    idle(); branch = 1'b1; funct3 = 3'b010; tick();                     // not taken
    idle();
    check("perf_pc", pc, 32'd32);
    check("perf_br_count", br_count, 32'd5);
    check("perf_br_taken_count", br_taken_count, 32'd3);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
